vga_timing_gen: RTL

//  Parametrised raster timing generator and pixel output stage. Successor to the fixed 640x480 generator.

---
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 96 +++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-request and pin-level output bundle of the raster timing generator
interface vga_timing_gen_if #(
  parameter int CNT_W = 10,
  parameter int COL_W = 4
);
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             req_active;
  logic [COL_W-1:0] r_in;
  logic [COL_W-1:0] g_in;
  logic [COL_W-1:0] b_in;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [COL_W-1:0] r;
  logic [COL_W-1:0] g;
  logic [COL_W-1:0] b;
  logic             line_start;
  logic             frame_start;
  modport master (
    output x, y, req_active, hsync, vsync, de, r, g, b, line_start, frame_start,
    input  r_in, g_in, b_in
  );
  modport slave (
    input  x, y, req_active, hsync, vsync, de, r, g, b, line_start, frame_start,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with latency-matched registered pixel output
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 1,
  parameter int CNT_W    = 10,
  parameter int COL_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  vga_timing_gen_if.master  bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } tag_t;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  tag_t             cur;
  tag_t             tap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (pix_ce) begin
      x <= (x == CNT_W'(H_TOTAL - 1)) ? '0 : x + CNT_W'(1);
      if (x == CNT_W'(H_TOTAL - 1))
        y <= (y == CNT_W'(V_TOTAL - 1)) ? '0 : y + CNT_W'(1);
    end
  always_comb begin
    cur.hs = (x >= CNT_W'(HS_START)) && (x < CNT_W'(HS_END));
    cur.vs = (y >= CNT_W'(VS_START)) && (y < CNT_W'(VS_END));
    cur.de = (x < CNT_W'(H_ACTIVE)) && (y < CNT_W'(V_ACTIVE));
    cur.ls = (x == '0);
    cur.fs = (x == '0) && (y == '0);
  end
  assign bus.x          = x;
  assign bus.y          = y;
  assign bus.req_active = cur.de;
  // timing tags ride alongside the pixel source so they meet rgb_in on the same tick
  generate
    if (PIX_LAT == 0) begin : g_direct
      assign tap = cur;
    end else begin : g_pipe
      tag_t sh [PIX_LAT];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int i = 0; i < PIX_LAT; i++) sh[i] <= '0;
        end else if (pix_ce) begin
          sh[0] <= cur;
          for (int i = 1; i < PIX_LAT; i++) sh[i] <= sh[i-1];
        end
      assign tap = sh[PIX_LAT-1];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.hsync       <= ~HS_POL;
      bus.vsync       <= ~VS_POL;
      bus.de          <= 1'b0;
      bus.r           <= '0;
      bus.g           <= '0;
      bus.b           <= '0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.line_start  <= pix_ce & tap.ls;
      bus.frame_start <= pix_ce & tap.fs;
      if (pix_ce) begin
        bus.hsync <= tap.hs ? HS_POL : ~HS_POL;
        bus.vsync <= tap.vs ? VS_POL : ~VS_POL;
        bus.de    <= tap.de;
        bus.r     <= tap.de ? bus.r_in : '0;
        bus.g     <= tap.de ? bus.g_in : '0;
        bus.b     <= tap.de ? bus.b_in : '0;
      end
    end
endmodule
